sequencer: RTL and testbench

- Next-PC selector and PC holder for the fetch stage of the 5-stage RV32 pipeline.
- Chooses between the branch/jump target from execute and the sequential PC+4 computed by fetch.
- Drives the combinational next PC and the instruction-memory word address.
- Keeps the architectural fetch PC register, a misalignment flag and redirect/sequential statistics counters.

---
 rtl/sequencer_pkg.sv | 6 +
 rtl/sequencer_seq_counter.sv | 18 +
 rtl/sequencer.sv | 54 +++++
 tb/tb_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// Shared constants for the fetch-stage next-PC sequencer.
package sequencer_pkg;
  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_7FFC;
  localparam int          WORD_SHIFT       = 2;
endpackage

// File: rtl/sequencer_seq_counter.sv
// Wrapping statistics counter with synchronous reset and count enable.
module seq_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (en)
      count <= count + W'(1);
  end

endmodule

// File: rtl/sequencer.sv
// Next-PC select, instruction word address, fetch PC register and redirect/sequential statistics.
module sequencer
  import sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_signal,
  input  logic [XLEN-1:0]  branch,
  input  logic [XLEN-1:0]  notbranch,
  input  logic             stall,
  output logic [XLEN-1:0]  npc,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  pc,
  output logic             misaligned,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] seq_cnt
);

  logic redirect_en;
  logic seq_en;

  // No low-bit masking: a misaligned target is flagged but still fetched as given.
  assign npc        = branch_signal ? branch : notbranch;
  assign imem_addr  = npc >> WORD_SHIFT;
  assign misaligned = (npc[1:0] != 2'b00);

  assign redirect_en = !stall &&  branch_signal;
  assign seq_en      = !stall && !branch_signal;

  always_ff @(posedge clk) begin
    if (reset)
      pc <= RESET_PC;
    else if (!stall)
      pc <= npc;
  end

  seq_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (redirect_en),
    .count (redirect_cnt)
  );

  seq_counter #(.W(CNT_W)) u_seq_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (seq_en),
    .count (seq_cnt)
  );

endmodule

// File: tb/tb_sequencer.sv
// Randomised bench for sequencer against a behavioural next-PC/counter model.
module tb_sequencer;
  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk;
  logic             reset;
  logic             branch_signal;
  logic [31:0]      branch;
  logic [31:0]      notbranch;
  logic             stall;
  logic [31:0]      npc;
  logic [31:0]      imem_addr;
  logic [31:0]      pc;
  logic             misaligned;
  logic [CNT_W-1:0] redirect_cnt;
  logic [CNT_W-1:0] seq_cnt;

  int total = 0;
  int bad   = 0;

  longint unsigned m_pc;
  int              m_redir;
  int              m_seq;

  sequencer #(.RESET_PC(32'h0000_7FFC), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .branch_signal (branch_signal),
    .branch        (branch),
    .notbranch     (notbranch),
    .stall         (stall),
    .npc           (npc),
    .imem_addr     (imem_addr),
    .pc            (pc),
    .misaligned    (misaligned),
    .redirect_cnt  (redirect_cnt),
    .seq_cnt       (seq_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply inputs, check combinational outputs, clock once, check registered state.
  task automatic cyc(input logic rst, input logic bs, input logic st,
                     input logic [31:0] br, input logic [31:0] nb);
    longint unsigned e_npc;
    reset = rst; branch_signal = bs; stall = st; branch = br; notbranch = nb;
    #1;
    e_npc = bs ? br : nb;
    check("npc", npc, 32'(e_npc));
    check("imem_addr", imem_addr, 32'(e_npc / 4));
    check("misaligned", {31'b0, misaligned}, {31'b0, (e_npc % 4) != 0});
    @(posedge clk);
    if (rst) begin
      m_pc = 64'h7FFC; m_redir = 0; m_seq = 0;
    end else if (!st) begin
      m_pc = e_npc;
      if (bs) m_redir = (m_redir + 1) % CNT_MOD;
      else    m_seq   = (m_seq + 1) % CNT_MOD;
    end
    #1;
    check("pc", pc, 32'(m_pc));
    check("redirect_cnt", 32'(redirect_cnt), 32'(m_redir));
    check("seq_cnt", 32'(seq_cnt), 32'(m_seq));
  endtask

  initial begin
    logic [31:0] rb;
    int          held_redir;
    m_pc = 0; m_redir = 0; m_seq = 0;

    // Reset for two cycles, then first sequential fetch.
    cyc(1, 0, 0, 32'h0, 32'h8000);
    cyc(1, 0, 0, 32'h0, 32'h8000);
    check("reset_pc", pc, 32'h0000_7FFC);
    cyc(0, 0, 0, 32'h0, 32'h8000);
    check("first_pc", pc, 32'h8000);
    check("first_seq", 32'(seq_cnt), 32'd1);

    // Combinational mux flip while stalled.
    cyc(0, 0, 1, 32'h8100, 32'h8004);
    check("flip_imem0", imem_addr, 32'h2001);
    cyc(0, 1, 1, 32'h8100, 32'h8004);
    check("flip_imem1", imem_addr, 32'h2040);

    // Redirect held across a three-cycle stall.
    held_redir = m_redir;
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 32'h9000, 32'h8004);
    check("stall_pc", pc, 32'h8000);
    cyc(0, 1, 0, 32'h9000, 32'h8004);
    check("redirect_pc", pc, 32'h9000);
    check("redirect_inc", 32'(redirect_cnt), 32'((held_redir + 1) % CNT_MOD));

    // Misaligned target passes through unmodified.
    branch = 32'h9002; branch_signal = 1'b1; stall = 1'b0; #1;
    check("mis_flag", {31'b0, misaligned}, 32'd1);
    check("mis_imem", imem_addr, 32'h2400);
    cyc(0, 1, 0, 32'h9002, 32'h9004);
    check("mis_pc", pc, 32'h9002);

    // Reset wins over a concurrent redirect.
    cyc(1, 1, 0, 32'hA000, 32'h9006);
    check("rst_pc", pc, 32'h7FFC);
    check("rst_redir", 32'(redirect_cnt), 32'd0);
    check("rst_npc", npc, 32'hA000);

    // Sequential run long enough to wrap seq_cnt.
    for (int i = 0; i < CNT_MOD; i++) cyc(0, 0, 0, 32'h0, 32'(m_pc + 4));
    check("wrap_seq", 32'(seq_cnt), 32'd0);
    check("wrap_pc", pc, 32'h7FFC + 32'(4 * CNT_MOD));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rb = $urandom;
      if ($urandom_range(0, 3) != 0) rb[1:0] = 2'b00;
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) == 0), rb, 32'(m_pc + 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
